// File: rtl/simprisc_pkg.sv
// Shared SimpRISC types: ALU opcode encoding, dispatcher FSM states and default widths.
package simprisc_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_NOT = 3'd2,
    ALU_LS  = 3'd3,
    ALU_RS  = 3'd4,
    ALU_AND = 3'd5,
    ALU_OR  = 3'd6,
    ALU_LT  = 3'd7
  } alu_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } disp_state_t;

endpackage

// File: rtl/simprisc_regfile.sv
// NREGS x DATA_W register file: three async read ports, one sync write port, r0 reads zero.
module simprisc_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  input  logic [AW-1:0]     raddr_d_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] rdata_d_o
);

  logic [NREGS-1:0][DATA_W-1:0] rf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_q <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  // r0 is forced at the read mux so it never depends on the storage contents
  assign rdata_a_o = (raddr_a_i == '0) ? '0 : rf_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : rf_q[raddr_b_i];
  assign rdata_d_o = (raddr_d_i == '0) ? '0 : rf_q[raddr_d_i];

endmodule

// File: rtl/alu_dispatch.sv
// Serialised ALU issue stage: latch instruction, read operands, drive ALU, capture and write back.
module alu_dispatch
  import simprisc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = 8,
  parameter int IMM_W  = 12,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  alu_sel_t          instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic [IMM_W-1:0]  instr_imm,
  input  logic              instr_use_imm,
  output alu_sel_t          alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_AW-1:0] res_rd,
  output logic              res_zero,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  disp_state_t state_q, state_d;

  alu_sel_t          op_q;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic [IMM_W-1:0]  imm_q;
  logic              use_imm_q;

  alu_sel_t          alu_sel_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [DATA_W-1:0] result_q;
  logic [REG_AW-1:0] res_rd_q;
  logic              res_zero_q;

  logic              accept;
  logic              rf_we;
  logic [DATA_W-1:0] rs1_data, rs2_data, imm_sext;

  simprisc_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (REG_AW)
  ) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rd_q),
    .wdata_i   (result_q),
    .raddr_a_i (rs1_q),
    .raddr_b_i (rs2_q),
    .raddr_d_i (dbg_addr),
    .rdata_a_o (rs1_data),
    .rdata_b_o (rs2_data),
    .rdata_d_o (dbg_data)
  );

  assign imm_sext = {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    instr_ready = (state_q == ST_IDLE);
    accept      = instr_valid && instr_ready;
    res_valid   = (state_q == ST_WB);
    rf_we       = res_valid && (rd_q != '0);
  end

  // Instruction fields are captured once so decode may change its outputs while we are busy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= ALU_ADD;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
    end else if (accept) begin
      op_q      <= instr_op;
      rd_q      <= instr_rd;
      rs1_q     <= instr_rs1;
      rs2_q     <= instr_rs2;
      imm_q     <= instr_imm;
      use_imm_q <= instr_use_imm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_sel_q  <= ALU_ADD;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      result_q   <= '0;
      res_rd_q   <= '0;
      res_zero_q <= 1'b1;
    end else begin
      if (state_q == ST_READ) begin
        alu_sel_q <= op_q;
        alu_a_q   <= rs1_data;
        alu_b_q   <= use_imm_q ? imm_sext : rs2_data;
      end
      // Result fields change only on entry to WB, so they hold between res_valid pulses
      if (state_q == ST_EXEC) begin
        result_q   <= alu_out;
        res_rd_q   <= rd_q;
        res_zero_q <= (alu_out == '0);
      end
    end
  end

  assign alu_sel  = alu_sel_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign res_data = result_q;
  assign res_rd   = res_rd_q;
  assign res_zero = res_zero_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch with a behavioural ALU on the alu_* signals.
module tb_alu_dispatch;
  import simprisc_pkg::*;

  localparam int DATA_W = 32;
  localparam int NREGS  = 8;
  localparam int IMM_W  = 12;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid;
  logic              instr_ready;
  alu_sel_t          instr_op;
  logic [AW-1:0]     instr_rd, instr_rs1, instr_rs2;
  logic [IMM_W-1:0]  instr_imm;
  logic              instr_use_imm;
  alu_sel_t          alu_sel;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [AW-1:0]     res_rd;
  logic              res_zero;
  logic [AW-1:0]     dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  alu_dispatch #(.DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .instr_imm(instr_imm), .instr_use_imm(instr_use_imm),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd), .res_zero(res_zero),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // The ALU the dispatcher drives: unsigned, wrapping
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_NOT: alu_out = ~alu_a;
      ALU_LS:  alu_out = alu_a << alu_b[4:0];
      ALU_RS:  alu_out = alu_a >> alu_b[4:0];
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_LT:  alu_out = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_out = '0;
    endcase
  end

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [AW-1:0]     rd;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every res_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_rd", {29'd0, res_rd}, {29'd0, e.rd});
        chk("res_zero", {31'd0, res_zero}, {31'd0, (e.data == 32'd0)});
        chk("latency", cyc, e.cyc);
      end
    end
  end

  // Present an instruction (caller at a negedge or just after an edge); waits for acceptance.
  task automatic issue(input alu_sel_t op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [IMM_W-1:0] imm, input logic use_imm,
                       input logic [DATA_W-1:0] exp_data, input bit push, output int acc_cyc);
    int guard;
    instr_valid   = 1'b1;
    instr_op      = op;
    instr_rd      = rd;
    instr_rs1     = rs1;
    instr_rs2     = rs2;
    instr_imm     = imm;
    instr_use_imm = use_imm;
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    if (push) exp_q.push_back('{data: exp_data, rd: rd, cyc: cyc + 3});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run1(input alu_sel_t op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                      input logic [AW-1:0] rs2, input logic [IMM_W-1:0] imm, input logic use_imm,
                      input logic [DATA_W-1:0] exp_data);
    int a;
    @(negedge clk);
    issue(op, rd, rs1, rs2, imm, use_imm, exp_data, 1'b1, a);
    instr_valid = 1'b0;
    drain();
  endtask

  task automatic chk_reg(input string name, input logic [AW-1:0] r, input logic [DATA_W-1:0] exp);
    dbg_addr = r;
    #1;
    chk(name, dbg_data, exp);
  endtask

  initial begin
    int a0, a1;
    rst_n = 1'b0; instr_valid = 1'b0; instr_op = ALU_ADD;
    instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0; instr_imm = '0; instr_use_imm = 1'b0;
    dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    // 1. reset state
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_alu_sel", {29'd0, alu_sel}, {29'd0, ALU_ADD});
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_res_zero", {31'd0, res_zero}, 32'd1);
    for (int r = 0; r < NREGS; r++) chk_reg($sformatf("rst_r%0d", r), AW'(r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. add immediate, subtract
    run1(ALU_ADD, 3'd1, 3'd0, 3'd0, 12'd5, 1'b1, 32'd5);
    chk_reg("r1_after_add", 3'd1, 32'd5);
    run1(ALU_SUB, 3'd2, 3'd0, 3'd1, 12'd0, 1'b0, 32'hFFFF_FFFB);

    // 3. sign extension and unsigned compare
    run1(ALU_ADD, 3'd3, 3'd0, 3'd0, 12'hFFF, 1'b1, 32'hFFFF_FFFF);
    run1(ALU_LT,  3'd4, 3'd3, 3'd1, 12'd0, 1'b0, 32'd0);
    run1(ALU_LT,  3'd4, 3'd1, 3'd3, 12'd0, 1'b0, 32'd1);
    chk_reg("r4_lt", 3'd4, 32'd1);

    // 4. write to r0 is reported but dropped
    run1(ALU_ADD, 3'd0, 3'd1, 3'd1, 12'd0, 1'b0, 32'd10);
    chk_reg("r0_still_zero", 3'd0, 32'd0);
    chk_reg("r1_unchanged", 3'd1, 32'd5);

    // 5. valid held high across two instructions; second fields change while first is busy
    @(negedge clk);
    issue(ALU_AND, 3'd6, 3'd2, 3'd0, 12'h0F0, 1'b1, 32'h0000_00F0, 1'b1, a0);
    chk("busy_ready_low", {31'd0, instr_ready}, 32'd0);
    issue(ALU_OR, 3'd7, 3'd6, 3'd1, 12'd0, 1'b0, 32'h0000_00F5, 1'b1, a1);
    instr_valid = 1'b0;
    chk("b2b_spacing", a1 - a0, 32'd4);
    drain();
    chk_reg("r6_and", 3'd6, 32'h0000_00F0);
    chk_reg("r7_or", 3'd7, 32'h0000_00F5);

    // 6. reset while the ADD is in EXEC: nothing written back
    @(negedge clk);
    issue(ALU_ADD, 3'd5, 3'd1, 3'd0, 12'd7, 1'b1, 32'd12, 1'b0, a0);
    instr_valid = 1'b0;
    @(negedge clk);                      // READ
    @(negedge clk);                      // EXEC
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_res_valid", {31'd0, res_valid}, 32'd0);
    rst_n = 1'b1;
    chk("rst_mid_ready", {31'd0, instr_ready}, 32'd1);
    chk_reg("r5_after_rst", 3'd5, 32'd0);
    chk_reg("r1_after_rst", 3'd1, 32'd0);
    repeat (4) @(negedge clk);
    chk("no_late_result", {31'd0, res_valid}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
